ram_arbiter: RTL and testbench

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arbiter.sv | 94 +++++++++
 tb/tb_ram_arbiter.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// ram_arbiter: two-requester single-port RAM arbiter with IDLE/ISSUE/RESP sequencing.
// Define RAM_ARB_ROUND_ROBIN_EN for round-robin contention; otherwise requester 0 has fixed priority.
module ram_arbiter #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_req0,
    input  logic                  i_req1,
    input  logic                  i_we0,
    input  logic                  i_we1,
    input  logic [ADDR_WIDTH-1:0] i_addr0,
    input  logic [ADDR_WIDTH-1:0] i_addr1,
    input  logic [DATA_WIDTH-1:0] i_data0,
    input  logic [DATA_WIDTH-1:0] i_data1,
    output logic                  o_gnt0,
    output logic                  o_gnt1,
    output logic                  o_rvalid0,
    output logic                  o_rvalid1,
    output logic [DATA_WIDTH-1:0] o_rdata,
    output logic [ADDR_WIDTH-1:0] o_ram_addr,
    output logic [DATA_WIDTH-1:0] o_ram_data,
    output logic                  o_ram_we,
    output logic                  o_ram_re,
    input  logic [DATA_WIDTH-1:0] i_ram_data,
    output logic                  o_busy
);
    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
    state_t                state_q, state_d;
    logic                  win_q, win_d, we_q, we_d, pick;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
`ifdef RAM_ARB_ROUND_ROBIN_EN
    logic last_q, last_d;
    assign pick = ~last_q;
    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) last_q <= 1'b1;
        else          last_q <= last_d;
`else
    assign pick = 1'b0;
`endif
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            win_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end
    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        we_d    = we_q;
        addr_d  = addr_q;
        data_d  = data_q;
`ifdef RAM_ARB_ROUND_ROBIN_EN
        last_d  = last_q;
`endif
        case (state_q)
            IDLE: if (i_req0 | i_req1) begin
                // a lone requester always wins; pick only breaks ties
                win_d   = (i_req0 & i_req1) ? pick : i_req1;
                we_d    = win_d ? i_we1 : i_we0;
                addr_d  = win_d ? i_addr1 : i_addr0;
                data_d  = win_d ? i_data1 : i_data0;
                state_d = ISSUE;
`ifdef RAM_ARB_ROUND_ROBIN_EN
                last_d  = win_d;
`endif
            end
            ISSUE:   state_d = we_q ? IDLE : RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    assign o_gnt0     = (state_q == ISSUE) & ~win_q;
    assign o_gnt1     = (state_q == ISSUE) & win_q;
    assign o_ram_we   = (state_q == ISSUE) & we_q;
    assign o_ram_re   = (state_q == ISSUE) & ~we_q;
    assign o_rvalid0  = (state_q == RESP) & ~win_q;
    assign o_rvalid1  = (state_q == RESP) & win_q;
    assign o_rdata    = (state_q == RESP) ? i_ram_data : '0;
    assign o_ram_addr = addr_q;
    assign o_ram_data = data_q;
    assign o_busy     = state_q != IDLE;
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed bench with a transaction-level occupancy model and a behavioural RAM.
module tb_ram_arbiter;
    logic       clk = 1'b0, rst_n = 1'b0;
    logic       req0 = 0, req1 = 0, we0 = 0, we1 = 0;
    logic [7:0] addr0 = 0, addr1 = 0, data0 = 0, data1 = 0;
    logic       gnt0, gnt1, rvalid0, rvalid1, ram_we, ram_re, busy;
    logic [7:0] rdata, ram_addr, ram_data;
    logic [7:0] ram [256] = '{default: 8'h00};
    logic [7:0] ram_q = 8'h00;
    logic [7:0] mem_m [256] = '{default: 8'h00};
    int         n_vec = 0, n_err = 0;
    int         cyc = 0, s_cyc = -1000;
    logic       s_we = 0, s_win = 0, last_win = 1;
    logic [7:0] s_addr = 0, s_data = 0, s_rexp = 0;

    ram_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req0(req0), .i_req1(req1), .i_we0(we0), .i_we1(we1),
        .i_addr0(addr0), .i_addr1(addr1), .i_data0(data0), .i_data1(data1),
        .o_gnt0(gnt0), .o_gnt1(gnt1), .o_rvalid0(rvalid0), .o_rvalid1(rvalid1),
        .o_rdata(rdata), .o_ram_addr(ram_addr), .o_ram_data(ram_data),
        .o_ram_we(ram_we), .o_ram_re(ram_re), .i_ram_data(ram_q), .o_busy(busy)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_we) ram[ram_addr] <= ram_data;
        if (ram_re) ram_q <= ram[ram_addr];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        s_cyc = -1000; s_we = 0; s_win = 0; s_addr = 0; s_data = 0; last_win = 1;
    endtask

    // Transaction model: an access sampled at edge c occupies the arbiter for 2 (write) or 3 (read) edges.
    initial forever begin
        @(negedge rst_n);
        model_reset();
    end
    initial forever begin
        logic w;
        @(posedge clk);
        cyc++;
        if (!rst_n) model_reset();
        else begin
            if (s_we && cyc == s_cyc + 1) mem_m[s_addr] = s_data;
            if (cyc >= s_cyc + (s_we ? 2 : 3) && (req0 || req1)) begin
`ifdef RAM_ARB_ROUND_ROBIN_EN
                w = (req0 && req1) ? !last_win : req1;
`else
                w = (req0 && req1) ? 1'b0 : req1;
`endif
                s_cyc = cyc; s_win = w; last_win = w;
                s_we   = w ? we1 : we0;
                s_addr = w ? addr1 : addr0;
                s_data = w ? data1 : data0;
                s_rexp = mem_m[s_addr];
            end
        end
    end

    initial forever begin
        logic g, rv;
        @(negedge clk);
        g  = (cyc == s_cyc);
        rv = !s_we && (cyc == s_cyc + 1);
        chk("gnt0", gnt0, g && !s_win);
        chk("gnt1", gnt1, g && s_win);
        chk("ram_we", ram_we, g && s_we);
        chk("ram_re", ram_re, g && !s_we);
        chk("rvalid0", rvalid0, rv && !s_win);
        chk("rvalid1", rvalid1, rv && s_win);
        chk("busy", busy, cyc >= s_cyc && cyc < s_cyc + (s_we ? 1 : 2));
        chk("ram_addr", ram_addr, s_addr);
        chk("ram_data", ram_data, s_data);
        if (rv) chk("rdata", rdata, s_rexp);
        if (!rst_n) chk("rdata_rst", rdata, 0);
    end

    initial begin
        int order[$];
        int exp_order[4];
        int pulses, consec;
        logic prev;
`ifdef RAM_ARB_ROUND_ROBIN_EN
        exp_order = '{0, 1, 0, 1};
`else
        exp_order = '{0, 0, 0, 0};
`endif
        repeat (2) @(negedge clk);
        chk("lit_rst_busy", busy, 0);
        chk("lit_rst_addr", ram_addr, 0);
        rst_n = 1;
        @(negedge clk);
        // single write 0x10 <- 0xA5
        req0 = 1; we0 = 1; addr0 = 8'h10; data0 = 8'hA5;
        @(negedge clk);
        req0 = 0;
        chk("lit_wr_gnt0", gnt0, 1);
        chk("lit_wr_we", ram_we, 1);
        chk("lit_wr_addr", ram_addr, 8'h10);
        chk("lit_wr_data", ram_data, 8'hA5);
        chk("lit_wr_busy", busy, 1);
        @(negedge clk);
        chk("lit_wr_we_off", ram_we, 0);
        chk("lit_wr_busy_off", busy, 0);
        chk("lit_wr_mem", ram[8'h10], 8'hA5);
        chk("lit_model_mem", mem_m[8'h10], 8'hA5);
        // read-back by requester 1
        req1 = 1; we1 = 0; addr1 = 8'h10;
        @(negedge clk);
        req1 = 0;
        chk("lit_rd_gnt1", gnt1, 1);
        chk("lit_rd_re", ram_re, 1);
        @(negedge clk);
        chk("lit_rd_rvalid1", rvalid1, 1);
        chk("lit_rd_rdata", rdata, 8'hA5);
        repeat (2) @(negedge clk);
        // contention from reset: both hold reads
        rst_n = 0;
        req0 = 1; we0 = 0; addr0 = 8'h10; req1 = 1; we1 = 0; addr1 = 8'h11;
        @(negedge clk);
        rst_n = 1;
        repeat (12) begin
            @(negedge clk);
            if (gnt0) order.push_back(0);
            if (gnt1) order.push_back(1);
        end
        req0 = 0; req1 = 0;
        chk("lit_cont_count", order.size(), 4);
        for (int i = 0; i < 4; i++) chk($sformatf("lit_cont_order%0d", i), (i < order.size()) ? order[i] : -1, exp_order[i]);
        repeat (4) @(negedge clk);
        // held write request
        req0 = 1; we0 = 1; addr0 = 8'h20; data0 = 8'h11;
        pulses = 0; consec = 0; prev = 0;
        repeat (8) begin
            @(negedge clk);
            if (ram_we) pulses++;
            if (ram_we && prev) consec++;
            prev = ram_we;
        end
        req0 = 0;
        chk("lit_held_pulses", pulses, 4);
        chk("lit_held_consec", consec, 0);
        repeat (3) @(negedge clk);
        // reset during ISSUE of a read
        req0 = 1; we0 = 0; addr0 = 8'h10;
        @(negedge clk);
        req0 = 0;
        chk("lit_mid_rd_gnt_pre", gnt0, 1);
        #1 rst_n = 0;
        #1;
        chk("lit_mid_rd_gnt", gnt0, 0);
        chk("lit_mid_rd_re", ram_re, 0);
        chk("lit_mid_rd_busy", busy, 0);
        chk("lit_mid_rd_addr", ram_addr, 0);
        @(negedge clk);
        rst_n = 1;
        prev = 0;
        repeat (3) begin
            @(negedge clk);
            prev = prev | rvalid0 | rvalid1;
        end
        chk("lit_mid_rd_no_rvalid", prev, 0);
        req1 = 1; we1 = 0; addr1 = 8'h10;
        @(negedge clk);
        req1 = 0;
        chk("lit_after_rst_gnt1", gnt1, 1);
        @(negedge clk);
        chk("lit_after_rst_rdata", rdata, 8'hA5);
        repeat (2) @(negedge clk);
        // reset right after a write 0x30 <- 0xFF is latched
        req0 = 1; we0 = 1; addr0 = 8'h30; data0 = 8'hFF;
        @(posedge clk);
        #1 rst_n = 0;
        req0 = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
        repeat (3) @(negedge clk);
        chk("lit_mid_wr_mem", ram[8'h30], 8'h00);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
